// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: state encoding,
// iteration count and the divide-by-zero quotient.
package muldiv_pkg;

  localparam int DATA_W   = 32;
  localparam int ITER_CNT = 32;

  localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes; the controller
// decides when to load and step, and consumes the next-step values directly.
module div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dvnd_i,
  input  logic [DATA_W-1:0] dvsr_i,
  output logic [DATA_W-1:0] quo_nxt_o,
  output logic [DATA_W-1:0] rem_nxt_o
);

  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvsr_q;
  logic [DATA_W:0]   shifted;
  logic              ge;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  always_comb begin
    shifted   = {rem_q, quo_q[DATA_W-1]};
    ge        = (shifted >= {1'b0, dvsr_q});
    rem_nxt_o = ge ? (shifted[DATA_W-1:0] - dvsr_q) : shifted[DATA_W-1:0];
    quo_nxt_o = {quo_q[DATA_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      quo_q  <= dvnd_i;
      rem_q  <= '0;
      dvsr_q <= dvsr_i;
    end else if (step) begin
      quo_q  <= quo_nxt_o;
      rem_q  <= rem_nxt_o;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: 32-cycle iterative div/divu/multu plus mthi/mtlo.
// Define HILO_MULDIV_FAST_MUL_EN for a single-cycle multu.
module hilo_muldiv
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              div,
  input  logic              divu,
  input  logic              multu,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] LAST_CNT = 5'(ITER_CNT - 1);

  function automatic logic [DATA_W-1:0] mag_of(input logic signed [DATA_W-1:0] v,
                                               input logic is_signed);
    if (is_signed && (v < 0)) mag_of = $unsigned(-v);
    else                      mag_of = $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    cond_neg = neg ? (~v + 32'd1) : v;
  endfunction

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                div0_q, div0_d;
  logic                quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

  logic [DATA_W-1:0]   op_a_q;
  logic [2*DATA_W-1:0] prod_q, prod_nxt;
  logic [DATA_W:0]     prod_sum;
  logic                div_load, mul_load, div_step;
  logic [DATA_W-1:0]   dvnd_mag, dvsr_mag, quo_nxt, rem_nxt;

  assign dvnd_mag = mag_of(rs_data, div);
  assign dvsr_mag = mag_of(rt_data, div);
  assign div_step = (state_q == ST_DIV) && !div0_q;

  div_core #(.DATA_W(DATA_W)) u_div_core (
    .clk       (clk),
    .load      (div_load),
    .step      (div_step),
    .dvnd_i    (dvnd_mag),
    .dvsr_i    (dvsr_mag),
    .quo_nxt_o (quo_nxt),
    .rem_nxt_o (rem_nxt)
  );

  // Shift-add multiply: the multiplier sits in the low half and drains out
  // of the LSB as partial sums enter from the top.
  always_comb begin
    prod_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, op_a_q} : '0);
    prod_nxt = {prod_sum, prod_q[DATA_W-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div0_d    = div0_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div_load  = 1'b0;
    mul_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (div || divu) begin
          div_load  = 1'b1;
          state_d   = ST_DIV;
          busy_d    = 1'b1;
          cnt_d     = '0;
          div0_d    = (rt_data == '0);
          quo_neg_d = div && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
          rem_neg_d = div && rs_data[DATA_W-1];
        end else if (multu) begin
`ifdef HILO_MULDIV_FAST_MUL_EN
          {hi_d, lo_d} = {32'b0, rs_data} * {32'b0, rt_data};
          done_d       = 1'b1;
`else
          mul_load = 1'b1;
          state_d  = ST_MUL;
          busy_d   = 1'b1;
          cnt_d    = '0;
`endif
        end else if (mthi) begin
          hi_d = rs_data;
        end else if (mtlo) begin
          lo_d = rs_data;
        end
      end
      ST_DIV: begin
        if (div0_q || (cnt_q == LAST_CNT)) begin
          lo_d    = div0_q ? DIV0_QUOT : cond_neg(quo_nxt, quo_neg_q);
          hi_d    = div0_q ? op_a_q    : cond_neg(rem_nxt, rem_neg_q);
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_MUL: begin
        if (cnt_q == LAST_CNT) begin
          {hi_d, lo_d} = prod_nxt;
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  // Operand datapath carries no reset; it is always reloaded on a start.
  always_ff @(posedge clk) begin
    if (div_load || mul_load) op_a_q <= rs_data;
    if (mul_load)                  prod_q <= {32'b0, rt_data};
    else if (state_q == ST_MUL)    prod_q <= prod_nxt;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv (both HILO_MULDIV_FAST_MUL_EN builds).
module tb_hilo_muldiv;

  logic        clk;
  logic        rst_n;
  logic        div, divu, multu, mthi, mtlo;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [4:0] C_DIV   = 5'b10000;
  localparam logic [4:0] C_DIVU  = 5'b01000;
  localparam logic [4:0] C_MULTU = 5'b00100;
  localparam logic [4:0] C_MTHI  = 5'b00010;
  localparam logic [4:0] C_MTLO  = 5'b00001;

  hilo_muldiv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .div     (div),
    .divu    (divu),
    .multu   (multu),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b);
    {div, divu, multu, mthi, mtlo} = cmd;
    rs_data = a;
    rt_data = b;
  endtask

  task automatic issue(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b);
    drive(cmd, a, b);
    tick();
    drive(5'b0, 32'h0, 32'h0);
  endtask

  // Wait for busy to drop (bounded), then check cycle count, results and done.
  task automatic finish_op(input string tag, input int elapsed, input int exp_cyc,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int el;
    el = elapsed;
    while (busy === 1'b1 && el < 100) begin
      tick();
      el++;
    end
    chk({tag, "_cycles"}, 32'(el), 32'(exp_cyc));
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    drive(5'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;

    // Signed divide -7/2, with an mthi attempt while busy.
    issue(C_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_busy", {31'b0, busy}, 32'd1);
    issue(C_MTHI, 32'hA5A5_A5A5, 32'h0);
    chk("mthi_busy_hi", hi, 32'h0);
    finish_op("div_m7_2", 1, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick();
    chk("div_m7_2_done_fall", {31'b0, done}, 32'd0);

    // mthi/mtlo in IDLE, and mthi winning over mtlo.
    issue(C_MTHI, 32'hA5A5_A5A5, 32'h0);
    chk("mthi_idle_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_idle_busy", {31'b0, busy}, 32'd0);
    chk("mthi_idle_done", {31'b0, done}, 32'd0);
    issue(C_MTLO, 32'h0BAD_F00D, 32'h0);
    chk("mtlo_idle_lo", lo, 32'h0BAD_F00D);
    chk("mtlo_idle_hi", hi, 32'hA5A5_A5A5);
    issue(C_MTHI | C_MTLO, 32'h5A5A_5A5A, 32'h0);
    chk("prio_mthi_hi", hi, 32'h5A5A_5A5A);
    chk("prio_mthi_lo", lo, 32'h0BAD_F00D);

    // Largest unsigned product.
    issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef HILO_MULDIV_FAST_MUL_EN
    chk("multu_max_busy", {31'b0, busy}, 32'd0);
    finish_op("multu_max", 0, 0, 32'hFFFF_FFFE, 32'h0000_0001);
`else
    chk("multu_max_busy", {31'b0, busy}, 32'd1);
    chk("multu_max_hold_hi", hi, 32'h5A5A_5A5A);
    finish_op("multu_max", 0, 32, 32'hFFFF_FFFE, 32'h0000_0001);
`endif
    tick();
    chk("multu_max_done_fall", {31'b0, done}, 32'd0);

    // divu 100/7, then back-to-back div 0x80000000 / -1 while done is high.
    issue(C_DIVU, 32'd100, 32'd7);
    finish_op("divu_100_7", 0, 32, 32'd2, 32'd14);
    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    chk("b2b_done", {31'b0, done}, 32'd0);
    finish_op("div_min_m1", 0, 32, 32'h0, 32'h8000_0000);
    tick();

    // Divide by zero: one busy cycle.
    issue(C_DIVU, 32'h0000_1234, 32'h0);
    chk("divu0_busy", {31'b0, busy}, 32'd1);
    finish_op("divu0", 0, 1, 32'h0000_1234, 32'hFFFF_FFFF);
    tick();
    chk("divu0_done_fall", {31'b0, done}, 32'd0);

    // div and multu together: divide wins (20 / -3 = -6 rem 2).
    issue(C_DIV | C_MULTU, 32'd20, 32'hFFFF_FFFD);
    chk("divmul_busy", {31'b0, busy}, 32'd1);
    finish_op("divmul", 0, 32, 32'd2, 32'hFFFF_FFFA);
    tick();

    // Reset during iteration 15 of a divide.
    issue(C_DIV, 32'd1000, 32'd7);
    for (int i = 0; i < 15; i++) tick();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_hi", hi, 32'h0);
    issue(C_DIVU, 32'd9, 32'd3);
    finish_op("divu_9_3", 0, 32, 32'h0, 32'd3);
    tick();

    // multu 3*5.
    issue(C_MULTU, 32'd3, 32'd5);
`ifdef HILO_MULDIV_FAST_MUL_EN
    chk("mul35_busy", {31'b0, busy}, 32'd0);
    finish_op("mul35", 0, 0, 32'h0, 32'd15);
`else
    chk("mul35_busy", {31'b0, busy}, 32'd1);
    finish_op("mul35", 0, 32, 32'h0, 32'd15);
`endif
    tick();
    chk("mul35_done_fall", {31'b0, done}, 32'd0);
    chk("mul35_busy_end", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port div, input, 1 bit: start a signed divide, rs/rt.
REQ-004 SHALL have port divu, input, 1 bit: start an unsigned divide, rs/rt.
REQ-005 SHALL have port multu, input, 1 bit: start an unsigned multiply, rs*rt.
REQ-006 SHALL have port mthi, input, 1 bit: write rs_data to HI.
REQ-007 SHALL have port mtlo, input, 1 bit: write rs_data to LO.
REQ-008 SHALL have port rs_data, input, 32 bits: dividend or multiplicand, and the mthi/mtlo source.
REQ-009 SHALL have port rt_data, input, 32 bits: divisor or multiplier.
REQ-010 SHALL have port hi, output, 32 bits: HI register (remainder, or upper product).
REQ-011 SHALL have port lo, output, 32 bits: LO register (quotient, or lower product).
REQ-012 SHALL have port busy, output, 1 bit: registered; operation in flight; CPU stalls mfhi/mflo and new HI/LO commands.
REQ-013 SHALL have port done, output, 1 bit: registered one-cycle pulse after HI/LO is updated by mul/div.

Function
REQ-014 SHALL implement states IDLE, DIV, MUL with a 5-bit iteration counter.
REQ-015 SHALL, in IDLE, sample commands each edge with priority div > divu > multu > mthi > mtlo; only the winner acts.
REQ-016 SHALL, on mthi/mtlo in IDLE, update HI/LO at that edge, stay IDLE, and leave busy and done low.
REQ-017 SHALL, on div/divu/multu at edge E, latch operands and enter DIV/MUL; busy=1 from E through E+32.
REQ-018 SHALL perform one radix-2 restoring-divide or shift-add-multiply step per cycle for 32 cycles.
REQ-019 SHALL, at edge E+32, write HI/LO, return to IDLE, drop busy, and set done for one cycle.
REQ-020 SHALL ignore every command while busy=1 and keep HI/LO stable until the final edge.
REQ-021 SHALL give multu a full 64-bit unsigned product: HI=bits 63:32, LO=bits 31:0.
REQ-022 SHALL give divu LO=floor(rs/rt) and HI=rs mod rt.
REQ-023 SHALL run div on magnitudes: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-024 SHALL give div 0x80000000 / 0xFFFFFFFF the result LO=0x80000000, HI=0.
REQ-025 SHALL, on divide by zero (div or divu), skip iteration and write LO=0xFFFFFFFF, HI=rs_data at edge E+1 (busy one cycle, then done).
REQ-026 SHALL accept a new command on the same edge that done is asserted (back-to-back).

Reset
REQ-027 SHALL, on rst_n low, immediately force IDLE, counter=0, hi=0, lo=0, busy=0, done=0.
REQ-028 SHALL abort an in-flight operation on reset with no HI/LO write, and accept commands from the first edge after rst_n rises.

Configuration
REQ-029 SHALL, with macro HILO_MULDIV_FAST_MUL_EN defined, complete multu in one cycle: HI/LO written at edge E, busy never set, done pulsed the following cycle.
REQ-030 SHALL, without HILO_MULDIV_FAST_MUL_EN, use the 32-cycle iterative multiply of REQ-017/REQ-018; divide timing is unaffected by the macro.

Structure
REQ-031 SHALL place the state encoding, ITER_CNT=32, and DIV0_QUOT=0xFFFFFFFF in shared package muldiv_pkg.
REQ-032 SHALL implement the restoring divider datapath (operands, partial remainder, quotient shift) as sub-module div_core.

Verification
REQ-033 SHALL cover multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 32 busy cycles HI=0xFFFFFFFE, LO=0x00000001, done one cycle.
REQ-034 SHALL cover div rs=-7 (0xFFFFFFF9), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu rs=100, rt=7 -> LO=14, HI=2.
REQ-035 SHALL cover divu rs=0x1234, rt=0 -> one busy cycle, then LO=0xFFFFFFFF, HI=0x1234.
REQ-036 SHALL cover mthi 0xA5A5A5A5 while busy -> HI unchanged; same mthi in IDLE -> HI=0xA5A5A5A5 next edge, no done.
REQ-037 SHALL cover rst_n low at iteration 15 of div -> hi=lo=0, busy=0 immediately; next divu 9/3 -> LO=3, HI=0.
REQ-038 SHALL cover div and multu asserted together -> divide performed; with HILO_MULDIV_FAST_MUL_EN, multu 3*5 -> LO=15 one edge later, busy stays 0.
